// File: rtl/usb_pkg.sv
// ============================================================================
// Module      : usb_pkg
// Description : Shared widths and arbiter state encoding for the USB datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_pkg;

    localparam int DATA_W      = 32;
    localparam int BE_W        = 4;
    localparam int PERIPH_ID_W = 4;
    localparam int HDR_LSB     = 28;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational find-first-set starting at a rotating pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int w_best;
    int w_dist;

    // The winner is the requester with the smallest forward distance from ptr.
    always_comb begin
        any    = |req;
        idx    = '0;
        w_best = N;
        w_dist = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + N - int'(ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/periph_tx_arbiter.sv
// ============================================================================
// Module      : periph_tx_arbiter
// Description : Round-robin, burst-bounded arbiter of peripheral TX queues
//               onto the single FT601 peripheral-to-host path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_tx_arbiter
    import usb_pkg::*;
#(
    parameter int NUM_PERIPHS = 8,
    parameter int MAX_BURST   = 16
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [NUM_PERIPHS-1:0]        periph_valid,
    input  logic [NUM_PERIPHS*DATA_W-1:0] periph_data,
    input  logic [NUM_PERIPHS*BE_W-1:0]   periph_be,
    input  logic [NUM_PERIPHS-1:0]        periph_last,
    output logic [NUM_PERIPHS-1:0]        periph_rd,
    input  logic                          read_periph_data,
    output logic                          periph_data_available,
    output logic [DATA_W-1:0]             data_i,
    output logic [BE_W-1:0]               i_valid,
    output logic [PERIPH_ID_W-1:0]        grant_id
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    arb_state_t             r_state, w_next_state;
    logic [PERIPH_ID_W-1:0] r_grant, w_next_grant;
    logic [PERIPH_ID_W-1:0] r_ptr,   w_next_ptr;
    logic [7:0]             r_cnt,   w_next_cnt;

    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [DATA_W-1:0]      w_sel_data;
    logic [BE_W-1:0]        w_sel_be;
    logic                   w_any;
    logic [PERIPH_ID_W-1:0] w_pick;
    logic                   w_pop;
    logic [7:0]             w_cnt_inc;
    logic [PERIPH_ID_W-1:0] w_ptr_inc;
    logic                   w_unused_hdr;

    assign grant_id     = r_grant;
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_ptr_inc    = (r_grant == PERIPH_ID_W'(NUM_PERIPHS - 1)) ? '0 : r_grant + 1'b1;
    assign w_unused_hdr = ^w_sel_data[DATA_W-1:HDR_LSB];

    rr_pick #(
        .N     (NUM_PERIPHS),
        .IDX_W (PERIPH_ID_W)
    ) u_rr_pick (
        .req (periph_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    // Head-of-queue view of the currently granted peripheral.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_be    = '0;
        for (int p = 0; p < NUM_PERIPHS; p++) begin
            if (r_grant == PERIPH_ID_W'(p)) begin
                w_sel_valid = periph_valid[p];
                w_sel_last  = periph_last[p];
                w_sel_data  = periph_data[p*DATA_W +: DATA_W];
                w_sel_be    = periph_be[p*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        w_next_state          = r_state;
        w_next_grant          = r_grant;
        w_next_ptr            = r_ptr;
        w_next_cnt            = r_cnt;
        w_pop                 = 1'b0;
        periph_rd             = '0;
        periph_data_available = 1'b0;
        data_i                = '0;
        i_valid               = '0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_grant = w_pick;
                    w_next_cnt   = '0;
                    w_next_state = SERVE;
                end
            end
            SERVE: begin
                periph_data_available = w_sel_valid;
                w_pop                 = read_periph_data & w_sel_valid;
                if (w_sel_valid) begin
                    data_i  = {r_grant, w_sel_data[HDR_LSB-1:0]};
                    i_valid = w_sel_be;
                end
                for (int p = 0; p < NUM_PERIPHS; p++) begin
                    periph_rd[p] = w_pop && (r_grant == PERIPH_ID_W'(p));
                end
                // Starvation, packet end and burst exhaustion all release alike.
                if (!w_sel_valid || (w_pop && (w_sel_last || (w_cnt_inc == c_max_burst)))) begin
                    w_next_state = IDLE;
                    w_next_ptr   = w_ptr_inc;
                end else if (w_pop) begin
                    w_next_cnt = w_cnt_inc;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_ptr   <= w_next_ptr;
            r_cnt   <= w_next_cnt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_periph_tx_arbiter.sv
// ============================================================================
// Module      : tb_periph_tx_arbiter
// Description : Directed and randomized bench for periph_tx_arbiter against a
//               cycle-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_tx_arbiter;

    localparam int N  = 8;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             rst_l;
    logic [N-1:0]     periph_valid;
    logic [N*32-1:0]  periph_data;
    logic [N*4-1:0]   periph_be;
    logic [N-1:0]     periph_last;
    logic [N-1:0]     periph_rd;
    logic             read_periph_data;
    logic             periph_data_available;
    logic [31:0]      data_i;
    logic [3:0]       i_valid;
    logic [3:0]       grant_id;

    logic [31:0] pdata [N];
    logic [3:0]  pbe   [N];

    int checks = 0;
    int errors = 0;

    int m_busy, m_grant, m_ptr, m_cnt;

    for (genvar p = 0; p < N; p++) begin : g_pack
        assign periph_data[p*32 +: 32] = pdata[p];
        assign periph_be[p*4 +: 4]     = pbe[p];
    end

    always #5 clk = ~clk;

    periph_tx_arbiter #(
        .NUM_PERIPHS (N),
        .MAX_BURST   (MB)
    ) dut (
        .clk                   (clk),
        .rst_l                 (rst_l),
        .periph_valid          (periph_valid),
        .periph_data           (periph_data),
        .periph_be             (periph_be),
        .periph_last           (periph_last),
        .periph_rd             (periph_rd),
        .read_periph_data      (read_periph_data),
        .periph_data_available (periph_data_available),
        .data_i                (data_i),
        .i_valid               (i_valid),
        .grant_id              (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare outputs with the model for the current inputs, then clock both.
    task automatic cyc();
        logic        e_avail, e_pop;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic [N-1:0] e_rd;
        int          found;
        #1;
        e_avail = (m_busy != 0) && periph_valid[m_grant];
        e_pop   = e_avail && read_periph_data;
        e_data  = e_avail ? ((32'(m_grant) << 28) | (pdata[m_grant] & 32'h0FFF_FFFF)) : 32'h0;
        e_be    = e_avail ? pbe[m_grant] : 4'h0;
        e_rd    = e_pop ? N'(1 << m_grant) : '0;
        chk("available", 32'(periph_data_available), 32'(e_avail));
        chk("data_i", data_i, e_data);
        chk("i_valid", 32'(i_valid), 32'(e_be));
        chk("periph_rd", 32'(periph_rd), 32'(e_rd));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        @(posedge clk);
        if (!rst_l) begin
            m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_busy == 0) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && periph_valid[(m_ptr + k) % N]) found = (m_ptr + k) % N;
            end
            if (found >= 0) begin
                m_busy = 1; m_grant = found; m_cnt = 0;
            end
        end else if (!periph_valid[m_grant]) begin
            m_busy = 0; m_ptr = (m_grant + 1) % N;
        end else if (e_pop) begin
            m_cnt++;
            if (periph_last[m_grant] || m_cnt == MB) begin
                m_busy = 0; m_ptr = (m_grant + 1) % N;
            end
        end
        #1;
    endtask

    initial begin
        int n3, c0, c1;
        logic [N-1:0] hist [40];

        rst_l = 1'b0; periph_valid = '0; periph_last = '0; read_periph_data = 1'b0;
        for (int p = 0; p < N; p++) begin pdata[p] = 32'(p) * 32'h0101_0101; pbe[p] = 4'(p + 1); end
        m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
        @(posedge clk); #1;
        cyc();
        chk("reset_grant", 32'(grant_id), 32'h0);
        chk("reset_avail", 32'(periph_data_available), 32'h0);
        rst_l = 1'b1;

        // Single requester on peripheral 2 with header nibble overwritten.
        periph_valid = 8'b0000_0100; pdata[2] = 32'hF000_0001; pbe[2] = 4'hF; read_periph_data = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("single_data", data_i, 32'h2000_0001);
            chk("single_be", 32'(i_valid), 32'hF);
            chk("single_rd", 32'(periph_rd), 32'h04);
            cyc();
        end

        // Reset mid-burst, then 0 beats 2 from a cleared pointer.
        rst_l = 1'b0;
        cyc();
        rst_l = 1'b1; #1;
        chk("midrst_data", data_i, 32'h0);
        chk("midrst_rd", 32'(periph_rd), 32'h0);
        periph_valid = 8'b0000_0101;
        cyc();
        #1; chk("midrst_winner", 32'(grant_id), 32'h0);

        // Burst limit between peripherals 0 and 1.
        rst_l = 1'b0; cyc(); rst_l = 1'b1;
        periph_valid = 8'b0000_0011; periph_last = '0; read_periph_data = 1'b1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 36; i++) begin
            #1; hist[i] = periph_rd;
            if (i < 34) begin c0 += int'(periph_rd[0]); c1 += int'(periph_rd[1]); end
            cyc();
        end
        chk("burst_pops0", 32'(c0), 32'd16);
        chk("burst_pops1", 32'(c1), 32'd16);
        chk("burst_bubble", 32'(hist[17]), 32'h0);
        chk("burst_back0", 32'(hist[35]), 32'h01);

        // Three-word packet on peripheral 3, peripheral 5 waiting.
        rst_l = 1'b0; cyc(); rst_l = 1'b1;
        periph_valid = 8'b0010_1000; n3 = 0;
        for (int i = 0; i < 8; i++) begin
            periph_last = (n3 == 2) ? 8'b0000_1000 : 8'h00;
            #1; n3 += int'(periph_rd[3]);
            cyc();
        end
        periph_last = '0;
        chk("pkt_pops3", 32'(n3), 32'd3);
        #1; chk("pkt_next_grant", 32'(grant_id), 32'd5);

        // Granted peripheral starves: release with no pop.
        periph_valid = '0; #1;
        chk("starve_rd", 32'(periph_rd), 32'h0);
        chk("starve_avail", 32'(periph_data_available), 32'h0);
        cyc();
        cyc();
        #1; chk("ignored_rd", 32'(periph_rd), 32'h0);

        // Wrap-around from peripheral 7 to 0.
        rst_l = 1'b0; cyc(); rst_l = 1'b1;
        periph_valid = 8'h80; cyc();
        periph_valid = 8'h81; periph_last = 8'h80; cyc();
        periph_last = '0; cyc();
        #1; chk("wrap_grant", 32'(grant_id), 32'h0);
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_l            = ($urandom_range(0, 299) != 0);
            periph_valid     = N'($urandom);
            periph_last      = N'($urandom & $urandom & $urandom);
            read_periph_data = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < N; p++) begin
                pdata[p] = $urandom;
                pbe[p]   = 4'($urandom);
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/periph_tx_arbiter.md
Name: periph_tx_arbiter

Overview:
Shares the FT601 controller's single peripheral-to-host path among NUM_PERIPHS peripheral TX queues. The block runs round-robin arbitration with bounded bursts and stamps the granted peripheral ID into each outgoing word's header nibble. It sits between the peripheral FIFOs and ft601_controller and drives that controller's periph_data_available, data_i and i_valid inputs. Its read_periph_data input comes from the controller.

Parameters:
NUM_PERIPHS, 8, number of requesting peripherals (legal range 1..16).
MAX_BURST, 16, maximum words popped per grant before forced re-arbitration (legal range 1..255).

Ports:
clk  input  1  system clock; all logic on rising edge
rst_l  input  1  synchronous active-low reset
periph_valid  input  NUM_PERIPHS  peripheral p has a word at its FIFO head
periph_data  input  NUM_PERIPHS*32  head word of peripheral p at bits [32p+31:32p]
periph_be  input  NUM_PERIPHS*4  byte enables of head word of peripheral p
periph_last  input  NUM_PERIPHS  head word of peripheral p ends a packet
periph_rd  output  NUM_PERIPHS  one-hot pop strobe to peripheral FIFO heads
read_periph_data  input  1  controller consumes the presented word this cycle
periph_data_available  output  1  data_i/i_valid hold a valid word
data_i  output  32  {grant_id, periph_data[g][27:0]}
i_valid  output  4  periph_be[g] passed through
grant_id  output  4  currently granted peripheral index

Behaviour:
- Reset (rst_l=0 at rising edge), including mid-burst:
  - state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0.
  - periph_rd=0, periph_data_available=0, data_i=0, i_valid=0.
- States IDLE, SERVE; grant_id, state, rr_ptr and burst_cnt are registered.
- IDLE:
  - Outputs are inactive.
  - If any periph_valid bit is set, pick the first set index searching upward from rr_ptr, wrapping at NUM_PERIPHS-1 to 0.
  - Load grant_id, clear burst_cnt, go to SERVE.
  - If no bit is set, stay in IDLE.
- SERVE with g=grant_id:
  - periph_data_available = periph_valid[g] (combinational).
  - data_i = {g[3:0], periph_data[g][27:0]}; i_valid = periph_be[g].
  - data_i and i_valid are forced to 0 when not available.
- Pop:
  - pop = read_periph_data & periph_data_available.
  - periph_rd[g] = pop, and it is the only bit that may be set.
  - read_periph_data while not available is ignored: no pop and no count change.
- SERVE -> IDLE, with rr_ptr <= (g+1) mod NUM_PERIPHS, on the first of:
  - (a) pop of a word with periph_last[g]=1;
  - (b) pop that brings burst_cnt+1 to MAX_BURST;
  - (c) periph_valid[g]=0, i.e. the peripheral starved; release that same cycle.
  - Otherwise stay in SERVE and burst_cnt += pop.
  - Simultaneous (a) and (b) is a single release.
- Latency:
  - A request in IDLE reaches available=1 in the next cycle.
  - Back-to-back pops at one word per clock are supported within a grant.
  - Each re-arbitration costs exactly one IDLE bubble cycle.
- Fairness:
  - A continuously requesting peripheral waits at most (NUM_PERIPHS-1)*(MAX_BURST+1) cycles.
  - Lowest index wins only when rr_ptr points to it.
- Width rules:
  - Header nibble bits [31:28] of peripheral data are overwritten.
  - grant_id is zero-extended to 4 bits.
  - burst_cnt is 8 bits and saturates by design at MAX_BURST.
- A valid bit dropping on a non-granted peripheral has no effect.
- periph_valid may change freely while not granted.

Decomposition:
- Shared package usb_pkg holds:
  - DATA_W=32, BE_W=4, PERIPH_ID_W=4, HDR_LSB=28;
  - the arb_state_t enum {IDLE, SERVE}.
- One natural sub-module, rr_pick: combinational find-first-set from a rotating pointer.
  - Inputs: req[NUM_PERIPHS], ptr.
  - Outputs: any, idx.
  - Reused later by the RX demux.

Test Plan:
- Reset mid-burst:
  - Stimulus: peripheral 2 granted, then rst_l=0 for 1 cycle.
  - Response: next cycle all outputs 0, state IDLE; after release, rr_ptr=0 and peripheral 0 wins over 2 if both request.
- Single requester:
  - Stimulus: periph_valid=8'b0000_0100, head 32'hF0000001, be 4'hF, read_periph_data held 1.
  - Response: one cycle later data_i=32'h20000001, i_valid=4'hF, periph_rd=8'h04 every cycle.
- Burst limit:
  - Stimulus: peripherals 0 and 1 always valid, last never set, MAX_BURST=16, read held 1.
  - Response: 16 pops from 0, one bubble, 16 pops from 1, then back to 0.
- Packet end:
  - Stimulus: peripheral 3 sends a 3-word packet with last on word 3; peripheral 5 is also valid.
  - Response: exactly 3 pops on periph_rd[3], then grant_id=5 after one bubble.
- Starvation and ignored reads:
  - Stimulus: granted peripheral drops valid.
  - Response: release that cycle with no periph_rd pulse.
  - Stimulus: read_periph_data=1 while available=0.
  - Response: periph_rd stays 0.
- Wrap-around:
  - Stimulus: grant_id=7, peripherals 7 and 0 valid, 7 pops last.
  - Response: rr_ptr=0, next grant_id=0.
